ovf_event_buffer: RTL and testbench

OVF_EVENT_BUFFER -- requirements
Module: ovf_event_buffer

---
 rtl/ovf_evt_pkg.sv | 10 +
 rtl/ovf_evt_fifo.sv | 40 ++++
 rtl/ovf_event_buffer.sv | 51 +++++
 tb/tb_ovf_event_buffer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ovf_evt_pkg.sv
// ovf_evt_pkg: shared event record type and default sizing constants for the overflow event buffer
package ovf_evt_pkg;
  localparam int OVF_EVT_DEPTH = 4;
  localparam int OVF_EVT_TS_W = 12;
  localparam logic [7:0] OVF_EVT_DROP_MAX = 8'd255;
  typedef struct packed {
    logic [OVF_EVT_TS_W-1:0] ts;
    logic [3:0] residue;
  } ovf_event_t;
endpackage

// File: rtl/ovf_evt_fifo.sv
// ovf_evt_fifo: show-ahead sync fifo (push/din in, pop, dout = head or 0 when empty, full/empty/count out)
module ovf_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign rd = pop & !empty;
  assign wr = push & (!full | rd);
  assign full = count == CAP;
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      if (wr & !rd) count <= count + 1'b1;
      else if (rd & !wr) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/ovf_event_buffer.sv
// ovf_event_buffer: timestamps accumulator overflows (enable, acc_out, acc_ovf in) into a fifo (ev_valid/ev_ready/ev_ts/ev_residue, occupancy, full, drop_cnt out)
module ovf_event_buffer
  import ovf_evt_pkg::*;
#(
  parameter int DEPTH = OVF_EVT_DEPTH,
  parameter int TS_W = OVF_EVT_TS_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [3:0]               acc_out,
  input  logic                     acc_ovf,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_ts,
  output logic [3:0]               ev_residue,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic [7:0]               drop_cnt
);
  logic [TS_W-1:0] ts;
  logic [TS_W+3:0] head;
  logic empty, push, pop, drop;
  assign push = enable & acc_ovf;
  assign pop = ev_valid & ev_ready;
  // a full buffer still takes the record when the head leaves on the same edge
  assign drop = push & full & !ev_ready;
  assign ev_valid = !empty;
  assign ev_ts = head[TS_W+3:4];
  assign ev_residue = head[3:0];
  ovf_evt_fifo #(.DEPTH(DEPTH), .W(TS_W + 4)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({ts, acc_out}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(occupancy)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      ts <= '0;
      drop_cnt <= '0;
    end else begin
      if (enable) ts <= ts + 1'b1;
      if (drop && drop_cnt != OVF_EVT_DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ovf_event_buffer.sv
// tb_ovf_event_buffer: directed self-checking bench for ovf_event_buffer
module tb_ovf_event_buffer;
  import ovf_evt_pkg::*;
  logic clk = 0, reset = 1, enable = 0, acc_ovf = 0, ev_ready = 0;
  logic [3:0] acc_out = 0;
  logic ev_valid, full;
  logic [11:0] ev_ts;
  logic [3:0] ev_residue;
  logic [2:0] occupancy;
  logic [7:0] drop_cnt;
  logic [11:0] ts_m = 0, last_ts = 0;
  logic [11:0] pts [5];
  int n_cmp = 0, n_bad = 0;
  ovf_event_t rec;

  ovf_event_buffer dut (
    .clk(clk), .reset(reset), .enable(enable), .acc_out(acc_out), .acc_ovf(acc_ovf),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts), .ev_residue(ev_residue),
    .occupancy(occupancy), .full(full), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    last_ts = ts_m;
    if (reset) ts_m = 0;
    else if (enable) ts_m = ts_m + 12'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    check("rst_valid", ev_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_full", full, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ts", ev_ts, 0);
    check("rst_res", ev_residue, 0);

    reset = 0; enable = 1;
    tick(); tick(); tick();
    acc_ovf = 1; acc_out = 4'h1;
    tick();
    acc_ovf = 0;
    check("one_valid", ev_valid, 1);
    check("one_ts", ev_ts, 3);
    check("one_res", ev_residue, 1);
    check("one_occ", occupancy, 1);
    tick(); tick();
    check("hold_valid", ev_valid, 1);
    check("hold_ts", ev_ts, 3);
    check("hold_res", ev_residue, 1);
    ev_ready = 1;
    tick();
    ev_ready = 0;
    check("pop_valid", ev_valid, 0);
    check("pop_ts0", ev_ts, 0);
    check("pop_res0", ev_residue, 0);

    acc_ovf = 1;
    for (int i = 1; i <= 5; i++) begin
      acc_out = 4'(i);
      pts[i-1] = ts_m;
      tick();
    end
    acc_ovf = 0;
    check("fill_full", full, 1);
    check("fill_occ", occupancy, 4);
    check("fill_drop", drop_cnt, 1);
    enable = 0; acc_ovf = 1;
    tick(); tick();
    check("dis_drop", drop_cnt, 1);
    check("dis_occ", occupancy, 4);
    check("dis_tshold", ts_m, pts[4] + 12'd1);
    acc_ovf = 0; enable = 1; ev_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_res%0d", i), ev_residue, i);
      check($sformatf("drain_ts%0d", i), ev_ts, pts[i-1]);
      tick();
    end
    check("drain_empty", ev_valid, 0);
    ev_ready = 0;

    acc_ovf = 1;
    for (int i = 6; i <= 9; i++) begin
      acc_out = 4'(i);
      tick();
    end
    acc_out = 4'hA; ev_ready = 1;
    tick();
    acc_ovf = 0;
    check("both_occ", occupancy, 4);
    check("both_full", full, 1);
    check("both_drop", drop_cnt, 1);
    for (int i = 7; i <= 10; i++) begin
      check($sformatf("both_res%0d", i), ev_residue, i);
      tick();
    end
    check("both_empty", ev_valid, 0);
    ev_ready = 0;

    while (ts_m != 12'hFFF) tick();
    acc_ovf = 1; acc_out = 4'h3;
    tick();
    acc_out = 4'h4;
    tick();
    acc_ovf = 0;
    check("wrap_ts0", ev_ts, 12'hFFF);
    check("wrap_res0", ev_residue, 3);
    ev_ready = 1;
    tick();
    check("wrap_ts1", ev_ts, 0);
    check("wrap_res1", ev_residue, 4);
    tick();
    ev_ready = 0;

    acc_ovf = 1;
    for (int i = 0; i < 300; i++) tick();
    check("sat_drop", drop_cnt, 255);
    check("sat_occ", occupancy, 4);
    enable = 0;
    tick(); tick();
    check("sat_dis", drop_cnt, 255);
    enable = 1; acc_ovf = 0; ev_ready = 1;
    tick();
    check("pre_rst_occ", occupancy, 3);
    reset = 1; acc_ovf = 1;
    tick();
    check("mid_valid", ev_valid, 0);
    check("mid_occ", occupancy, 0);
    check("mid_drop", drop_cnt, 0);
    check("mid_ts", ev_ts, 0);
    check("mid_full", full, 0);
    reset = 0; ev_ready = 0; acc_out = 4'hC;
    rec.ts = ts_m; rec.residue = acc_out;
    tick();
    acc_ovf = 0;
    check("post_rec", {ev_ts, ev_residue}, rec);
    check("post_occ", occupancy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
